// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared by the encoder and the decoder side:
// opcodes, functs, FPU fmt codes and the request-kind enumeration.
package mips_isa_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0e;
   localparam logic [5:0] OP_JUMP  = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_FR    = 6'h11;
   localparam logic [5:0] OP_LWC1  = 6'h31;
   localparam logic [5:0] OP_SWC1  = 6'h39;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SLT  = 6'h2a;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_MULT = 6'h18;
   localparam logic [5:0] FN_MFHI = 6'h10;
   localparam logic [5:0] FN_MFLO = 6'h12;

   localparam logic [4:0] FMT_SINGLE = 5'h10;
   localparam logic [4:0] FMT_DOUBLE = 5'h11;

   localparam logic [5:0] FFN_ADD = 6'h00;
   localparam logic [5:0] FFN_SUB = 6'h01;

   typedef enum logic [4:0] {
      K_ADD   = 5'd0,
      K_SUB   = 5'd1,
      K_SLT   = 5'd2,
      K_JR    = 5'd3,
      K_MULT  = 5'd4,
      K_MFHI  = 5'd5,
      K_MFLO  = 5'd6,
      K_LW    = 5'd7,
      K_SW    = 5'd8,
      K_BEQ   = 5'd9,
      K_BNE   = 5'd10,
      K_ADDI  = 5'd11,
      K_XORI  = 5'd12,
      K_J     = 5'd13,
      K_JAL   = 5'd14,
      K_ADD_S = 5'd15,
      K_SUB_S = 5'd16,
      K_LWC1  = 5'd17,
      K_SWC1  = 5'd18
   } kind_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_FULL  = 2'd2
   } enc_state_e;

   function automatic logic [31:0] r_word(
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic [4:0] rd,
      input logic [5:0] fn
   );
      return {OP_RTYPE, rs, rt, rd, 5'h0, fn};
   endfunction

   function automatic logic [31:0] i_word(
      input logic [5:0]  op,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [15:0] imm
   );
      return {op, rs, rt, imm};
   endfunction

endpackage

// File: rtl/instruction_word_pack.sv
// Combinational kind+fields -> 32-bit MIPS word with a legal flag.
// FPU kinds are encoded only when FPU_ENCODE_EN is defined.
module instruction_word_pack
   import mips_isa_pkg::*;
(
   input  logic [4:0]  kind,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        legal
);

   // Decode the kind; anything not listed is reported illegal.
   always_comb begin
      word  = 32'h0;
      legal = 1'b1;
      case (kind)
         K_ADD:   word = r_word(rs, rt, rd, FN_ADD);
         K_SUB:   word = r_word(rs, rt, rd, FN_SUB);
         K_SLT:   word = r_word(rs, rt, rd, FN_SLT);
         K_JR:    word = {OP_RTYPE, rs, 15'h0, FN_JR};
         K_MULT:  word = {OP_RTYPE, rs, rt, 10'h0, FN_MULT};
         K_MFHI:  word = {OP_RTYPE, 10'h0, rd, 5'h0, FN_MFHI};
         K_MFLO:  word = {OP_RTYPE, 10'h0, rd, 5'h0, FN_MFLO};
         K_LW:    word = i_word(OP_LW, rs, rt, imm);
         K_SW:    word = i_word(OP_SW, rs, rt, imm);
         K_BEQ:   word = i_word(OP_BEQ, rs, rt, imm);
         K_BNE:   word = i_word(OP_BNE, rs, rt, imm);
         K_ADDI:  word = i_word(OP_ADDI, rs, rt, imm);
         K_XORI:  word = i_word(OP_XORI, rs, rt, imm);
         K_J:     word = {OP_JUMP, target};
         K_JAL:   word = {OP_JAL, target};
`ifdef FPU_ENCODE_EN
         K_ADD_S: word = {OP_FR, FMT_SINGLE, rt, rs, rd, FFN_ADD};
         K_SUB_S: word = {OP_FR, FMT_SINGLE, rt, rs, rd, FFN_SUB};
         K_LWC1:  word = i_word(OP_LWC1, rs, rt, imm);
         K_SWC1:  word = i_word(OP_SWC1, rs, rt, imm);
`endif
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/instruction_encoder.sv
// Accepts field-level requests, encodes them and streams registered
// writes into instruction memory. FPU kinds need FPU_ENCODE_EN.
module instruction_encoder
   import mips_isa_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_kind,
   input  logic [4:0]  req_rs,
   input  logic [4:0]  req_rt,
   input  logic [4:0]  req_rd,
   input  logic [15:0] req_imm,
   input  logic [25:0] req_target,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        err,
   output logic        full,
   output logic [15:0] words_written
);

   localparam logic [15:0] LAST_IDX = 16'(DEPTH_WORDS - 1);

   enc_state_e  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic        err_q, err_d;
   logic [15:0] count_q, count_d;

   logic [31:0] enc_word;
   logic        enc_legal;

   instruction_word_pack u_pack (
      .kind   (req_kind),
      .rs     (req_rs),
      .rt     (req_rt),
      .rd     (req_rd),
      .imm    (req_imm),
      .target (req_target),
      .word   (enc_word),
      .legal  (enc_legal)
   );

   assign imem_we       = we_q;
   assign imem_addr     = addr_q;
   assign imem_wdata    = wdata_q;
   assign err           = err_q;
   assign words_written = count_q;

   // Next-state, handshake and write-bundle logic.
   // The address holds on the last word so it never passes the top.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = 1'b0;
      err_d     = 1'b0;
      count_d   = count_q;
      req_ready = 1'b0;
      full      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (enc_legal) begin
                  wdata_d = enc_word;
                  we_d    = 1'b1;
                  state_d = ST_WRITE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_WRITE: begin
            count_d = count_q + 16'd1;
            if (count_q == LAST_IDX) begin
               state_d = ST_FULL;
            end else begin
               addr_d  = addr_q + 32'd4;
               state_d = ST_IDLE;
            end
         end
         ST_FULL: begin
            full = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= BASE_ADDR;
         wdata_q <= 32'h0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         count_q <= 16'h0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         err_q   <= err_d;
         count_q <= count_d;
      end
   end

endmodule
